// File: rtl/pi_inject_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pi_inject_ctrl_pkg: shared defaults, slot decode type and helpers for the
// Pi-tree leaf injection controller.                         Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pi_inject_ctrl_pkg;

   localparam int PI_N_DEFAULT      = 8;
   localparam int PI_D_W_DEFAULT    = 32;
   localparam int PI_DEPTH_DEFAULT  = 4;
   localparam int PI_STARVE_DEFAULT = 15;

   localparam int                         PI_STARVE_CNT_W = 8;
   localparam logic [PI_STARVE_CNT_W-1:0] PI_STARVE_MAX   = '1;

   // What the single output slot toward the leaf router carries this cycle.
   typedef enum logic [1:0] {
      SLOT_EMPTY  = 2'd0,
      SLOT_INJECT = 2'd1,
      SLOT_RECIRC = 2'd2
   } slot_e;

   function automatic int pi_addr_w(input int n);
      return $clog2(n) + 1;
   endfunction

   function automatic logic [PI_STARVE_CNT_W-1:0] pi_sat_inc(
      input logic [PI_STARVE_CNT_W-1:0] v
   );
      return (v == PI_STARVE_MAX) ? v : v + 1'b1;
   endfunction

endpackage : pi_inject_ctrl_pkg

`default_nettype wire

// File: rtl/pi_inject_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// pi_sync_fifo: registered synchronous FIFO, no bypass, async active-low
// reset, occupancy output.                                   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pi_sync_fifo
   import pi_inject_ctrl_pkg::*;
#(
   parameter int W     = 36,
   parameter int DEPTH = PI_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     pop_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i  & ~empty_o;

   // DEPTH is a power of two, so pointer wrap is plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule : pi_sync_fifo

`default_nettype wire

// File: rtl/pi_inject_ctrl.sv
// ---------------------------------------------------------------------------
// pi_inject_ctrl: leaf injection/ejection controller for the deflection
// Pi-tree NoC with injection-starvation status.              Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pi_inject_ctrl
   import pi_inject_ctrl_pkg::*;
#(
   parameter int N      = PI_N_DEFAULT,
   parameter int A_W    = pi_addr_w(N),
   parameter int D_W    = PI_D_W_DEFAULT,
   parameter int DEPTH  = PI_DEPTH_DEFAULT,
   parameter int STARVE = PI_STARVE_DEFAULT,
   parameter int POSX   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   c_i_v,
   input  logic [A_W-1:0]         c_i_addr,
   input  logic [D_W-1:0]         c_i_d,
   output logic                   c_i_rdy,
   output logic                   c_o_v,
   output logic [D_W-1:0]         c_o_d,
   input  logic                   n_i_v,
   input  logic [A_W-1:0]         n_i_addr,
   input  logic [D_W-1:0]         n_i_d,
   output logic                   n_o_v,
   output logic [A_W-1:0]         n_o_addr,
   output logic [D_W-1:0]         n_o_d,
   output logic [$clog2(DEPTH):0] fifo_cnt,
   output logic                   starve_o
);

   localparam int PKT_W = A_W + D_W;
   localparam logic [PI_STARVE_CNT_W-1:0] STARVE_TH = PI_STARVE_CNT_W'(STARVE);

   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [PKT_W-1:0]           fifo_head;

   logic                       eject;
   logic                       recirc;
   logic                       inject;
   slot_e                      slot;

   logic                       c_o_v_q,    c_o_v_d;
   logic [D_W-1:0]             c_o_d_q,    c_o_d_d;
   logic                       n_o_v_q,    n_o_v_d;
   logic [A_W-1:0]             n_o_addr_q, n_o_addr_d;
   logic [D_W-1:0]             n_o_d_q,    n_o_d_d;
   logic [PI_STARVE_CNT_W-1:0] blk_q,      blk_d;
   logic                       starve_q,   starve_d;

   // Network inputs only matter on an enabled cycle; the routers share ce.
   assign eject  = ce & n_i_v & (n_i_addr == A_W'(POSX));
   assign recirc = ce & n_i_v & ~eject;
   assign inject = ce & ~recirc & ~fifo_empty;

   assign c_i_rdy   = rst & ce & ~fifo_full;
   assign fifo_push = c_i_v & c_i_rdy;
   assign fifo_pop  = inject;

   pi_sync_fifo #(
      .W     (PKT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .wdata_i ({c_i_addr, c_i_d}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .cnt_o   (fifo_cnt)
   );

   always_comb begin
      slot = SLOT_EMPTY;
      if (recirc) begin
         slot = SLOT_RECIRC;
      end else if (inject) begin
         slot = SLOT_INJECT;
      end
   end

   always_comb begin
      c_o_v_d    = c_o_v_q;
      c_o_d_d    = c_o_d_q;
      n_o_v_d    = n_o_v_q;
      n_o_addr_d = n_o_addr_q;
      n_o_d_d    = n_o_d_q;
      blk_d      = blk_q;
      starve_d   = starve_q;
      if (ce) begin
         c_o_v_d = eject;
         c_o_d_d = n_i_d;
         case (slot)
            SLOT_RECIRC: begin
               n_o_v_d    = 1'b1;
               n_o_addr_d = n_i_addr;
               n_o_d_d    = n_i_d;
            end
            SLOT_INJECT: begin
               n_o_v_d                = 1'b1;
               {n_o_addr_d, n_o_d_d} = fifo_head;
            end
            default: begin
               n_o_v_d    = 1'b0;
               n_o_addr_d = '0;
               n_o_d_d    = '0;
            end
         endcase
         // A blocked cycle is one where a packet waits behind a recirculation.
         if (recirc && !fifo_empty) begin
            blk_d = pi_sat_inc(blk_q);
         end else begin
            blk_d = '0;
         end
         starve_d = (blk_d >= STARVE_TH);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_o_v_q    <= 1'b0;
         c_o_d_q    <= '0;
         n_o_v_q    <= 1'b0;
         n_o_addr_q <= '0;
         n_o_d_q    <= '0;
         blk_q      <= '0;
         starve_q   <= 1'b0;
      end else begin
         c_o_v_q    <= c_o_v_d;
         c_o_d_q    <= c_o_d_d;
         n_o_v_q    <= n_o_v_d;
         n_o_addr_q <= n_o_addr_d;
         n_o_d_q    <= n_o_d_d;
         blk_q      <= blk_d;
         starve_q   <= starve_d;
      end
   end

   assign c_o_v    = c_o_v_q;
   assign c_o_d    = c_o_d_q;
   assign n_o_v    = n_o_v_q;
   assign n_o_addr = n_o_addr_q;
   assign n_o_d    = n_o_d_q;
   assign starve_o = starve_q;

endmodule : pi_inject_ctrl

`default_nettype wire

// File: tb/tb_pi_inject_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pi_inject_ctrl: directed self-checking bench for pi_inject_ctrl.
//                                                            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pi_inject_ctrl;

   localparam int A_W   = 4;
   localparam int D_W   = 32;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   ce;
   logic                   c_i_v;
   logic [A_W-1:0]         c_i_addr;
   logic [D_W-1:0]         c_i_d;
   logic                   c_i_rdy;
   logic                   c_o_v;
   logic [D_W-1:0]         c_o_d;
   logic                   n_i_v;
   logic [A_W-1:0]         n_i_addr;
   logic [D_W-1:0]         n_i_d;
   logic                   n_o_v;
   logic [A_W-1:0]         n_o_addr;
   logic [D_W-1:0]         n_o_d;
   logic [$clog2(DEPTH):0] fifo_cnt;
   logic                   starve_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pi_inject_ctrl #(
      .N      (8),
      .A_W    (A_W),
      .D_W    (D_W),
      .DEPTH  (DEPTH),
      .STARVE (15),
      .POSX   (0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .c_i_v    (c_i_v),
      .c_i_addr (c_i_addr),
      .c_i_d    (c_i_d),
      .c_i_rdy  (c_i_rdy),
      .c_o_v    (c_o_v),
      .c_o_d    (c_o_d),
      .n_i_v    (n_i_v),
      .n_i_addr (n_i_addr),
      .n_i_d    (n_i_d),
      .n_o_v    (n_o_v),
      .n_o_addr (n_o_addr),
      .n_o_d    (n_o_d),
      .fifo_cnt (fifo_cnt),
      .starve_o (starve_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b0;
      ce       = 1'b1;
      c_i_v    = 1'b0;
      c_i_addr = '0;
      c_i_d    = '0;
      n_i_v    = 1'b0;
      n_i_addr = '0;
      n_i_d    = '0;

      // Reset held for three cycles, then released
      tick(); tick(); tick();
      chk("rst_n_o_v",    64'(n_o_v),    64'(0));
      chk("rst_c_o_v",    64'(c_o_v),    64'(0));
      chk("rst_fifo_cnt", 64'(fifo_cnt), 64'(0));
      chk("rst_starve",   64'(starve_o), 64'(0));
      chk("rst_c_i_rdy",  64'(c_i_rdy),  64'(0));
      rst = 1'b1;
      tick();
      chk("rel_c_i_rdy",  64'(c_i_rdy),  64'(1));
      chk("rel_n_o_v",    64'(n_o_v),    64'(0));
      chk("rel_fifo_cnt", 64'(fifo_cnt), 64'(0));

      // Idle inject: push at t, visible on n_o at t+2
      c_i_v = 1'b1; c_i_addr = 4'd5; c_i_d = 32'hA5;
      tick();
      c_i_v = 1'b0;
      chk("inj_cnt_t1",  64'(fifo_cnt), 64'(1));
      chk("inj_n_o_v_t1", 64'(n_o_v),   64'(0));
      tick();
      chk("inj_n_o_v",   64'(n_o_v),    64'(1));
      chk("inj_n_o_addr", 64'(n_o_addr), 64'(5));
      chk("inj_n_o_d",   64'(n_o_d),    64'(32'hA5));
      chk("inj_cnt_t2",  64'(fifo_cnt), 64'(0));
      tick();
      chk("inj_idle_v",    64'(n_o_v),    64'(0));
      chk("inj_idle_addr", 64'(n_o_addr), 64'(0));
      chk("inj_idle_d",    64'(n_o_d),    64'(0));

      // Eject frees the slot, so the queued head injects the same cycle
      c_i_v = 1'b1; c_i_addr = 4'd6; c_i_d = 32'h66;
      tick();
      c_i_v = 1'b0;
      n_i_v = 1'b1; n_i_addr = 4'd0; n_i_d = 32'h1234;
      tick();
      n_i_v = 1'b0;
      chk("ej_c_o_v",    64'(c_o_v),    64'(1));
      chk("ej_c_o_d",    64'(c_o_d),    64'(32'h1234));
      chk("ej_n_o_v",    64'(n_o_v),    64'(1));
      chk("ej_n_o_addr", 64'(n_o_addr), 64'(6));
      chk("ej_n_o_d",    64'(n_o_d),    64'(32'h66));
      chk("ej_cnt",      64'(fifo_cnt), 64'(0));
      tick();
      chk("ej_c_o_v_off", 64'(c_o_v), 64'(0));
      chk("ej_n_o_v_off", 64'(n_o_v), 64'(0));

      // ce=0 holds everything and ignores the network input
      c_i_v = 1'b1; c_i_addr = 4'd7; c_i_d = 32'h77;
      tick();
      c_i_v = 1'b0;
      ce = 1'b0;
      n_i_v = 1'b1; n_i_addr = 4'd0; n_i_d = 32'hDEAD;
      #1;
      chk("ce0_c_i_rdy", 64'(c_i_rdy), 64'(0));
      tick();
      chk("ce0_n_o_v",   64'(n_o_v),    64'(0));
      chk("ce0_c_o_v",   64'(c_o_v),    64'(0));
      chk("ce0_cnt",     64'(fifo_cnt), 64'(1));
      ce = 1'b1;
      n_i_v = 1'b0;
      tick();
      chk("ce1_n_o_v",   64'(n_o_v),    64'(1));
      chk("ce1_n_o_d",   64'(n_o_d),    64'(32'h77));
      chk("ce1_cnt",     64'(fifo_cnt), 64'(0));
      tick();

      // Recirculation fills the FIFO and starves injection
      for (int k = 1; k <= 20; k++) begin
         c_i_v    = 1'b1;
         c_i_addr = A_W'((k <= 5) ? k : 5);
         c_i_d    = 32'h100 + 32'((k <= 5) ? k : 5);
         n_i_v    = 1'b1;
         n_i_addr = 4'd3;
         n_i_d    = 32'h300 + 32'(k);
         tick();
         chk("rc_n_o_v",    64'(n_o_v),    64'(1));
         chk("rc_n_o_addr", 64'(n_o_addr), 64'(3));
         chk("rc_n_o_d",    64'(n_o_d),    64'(32'h300 + 32'(k)));
         chk("rc_cnt",      64'(fifo_cnt), 64'((k < 4) ? k : 4));
         chk("rc_c_i_rdy",  64'(c_i_rdy),  64'((k < 4) ? 1 : 0));
         chk("rc_starve",   64'(starve_o), 64'((k >= 16) ? 1 : 0));
      end
      // Drain in order; the held fifth packet enters once a slot frees
      n_i_v = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         tick();
         if (j == 2) c_i_v = 1'b0;
         chk("dr_n_o_v",    64'(n_o_v),    64'(1));
         chk("dr_n_o_addr", 64'(n_o_addr), 64'(j));
         chk("dr_n_o_d",    64'(n_o_d),    64'(32'h100 + 32'(j)));
         chk("dr_cnt",      64'(fifo_cnt), 64'((j <= 2) ? 3 : 5 - j));
         chk("dr_starve",   64'(starve_o), 64'(0));
      end
      tick();
      chk("dr_idle", 64'(n_o_v), 64'(0));

      // Streaming with continuous pop across pointer wrap
      for (int k = 1; k <= 11; k++) begin
         c_i_v    = (k <= 10);
         c_i_addr = A_W'(k & 7);
         c_i_d    = 32'h500 + 32'(k);
         tick();
         chk("st_cnt", 64'(fifo_cnt), 64'((k <= 10) ? 1 : 0));
         if (k == 1) begin
            chk("st_n_o_v_first", 64'(n_o_v), 64'(0));
         end else begin
            chk("st_n_o_v",    64'(n_o_v),    64'(1));
            chk("st_n_o_addr", 64'(n_o_addr), 64'((k - 1) & 7));
            chk("st_n_o_d",    64'(n_o_d),    64'(32'h500 + 32'(k - 1)));
         end
      end
      c_i_v = 1'b0;
      tick();

      // Mid-operation reset discards queue and in-flight output
      for (int k = 1; k <= 3; k++) begin
         c_i_v    = 1'b1;
         c_i_addr = 4'd2;
         c_i_d    = 32'h600 + 32'(k);
         n_i_v    = 1'b1;
         n_i_addr = 4'd3;
         n_i_d    = 32'h700 + 32'(k);
         tick();
      end
      chk("mr_pre_cnt",  64'(fifo_cnt), 64'(3));
      chk("mr_pre_n_o_v", 64'(n_o_v),   64'(1));
      rst = 1'b0;
      #1;
      chk("mr_n_o_v",    64'(n_o_v),    64'(0));
      chk("mr_n_o_addr", 64'(n_o_addr), 64'(0));
      chk("mr_n_o_d",    64'(n_o_d),    64'(0));
      chk("mr_cnt",      64'(fifo_cnt), 64'(0));
      chk("mr_c_i_rdy",  64'(c_i_rdy),  64'(0));
      c_i_v = 1'b0;
      n_i_v = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("mr_rel_n_o_v", 64'(n_o_v),    64'(0));
      chk("mr_rel_cnt",   64'(fifo_cnt), 64'(0));
      tick();
      chk("mr_rel2_n_o_v", 64'(n_o_v),   64'(0));
      chk("mr_rel_c_i_rdy", 64'(c_i_rdy), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_pi_inject_ctrl

`default_nettype wire
